first_nios2_system_onchip_mem_arbiter: RTL

Two-master arbiter that shares the single-port 32-bit on-chip memory between the Nios II data master (m0) and the DMA master (m1). It sits between the two Avalon-MM masters and the memory's s1 slave port. It grants one access per cycle, routes the fixed one-cycle read data back to the issuing master, and blocks out-of-range accesses.

---
 rtl/first_nios2_system_onchip_mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/first_nios2_system_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// first_nios2_system_onchip_mem_arbiter
//
// Shares the single-port 32-bit on-chip memory (s1 slave) between the Nios II
// data master (m0) and the DMA master (m1). One access is granted per cycle.
// Read data comes back one cycle after the accept and is steered to the issuing
// master. Word addresses at or above DEPTH are accepted but never reach the
// memory: writes are dropped and reads return zero.
//
// Configuration macro:
//   ONCHIP_ARB_FIXED_PRIORITY_EN  defined   -> m0 always wins contention
//                                 undefined -> round-robin on a last-grant bit
//
// Ports (N = 0, 1):
//   clk, reset_n          clock, asynchronous active-low reset
//   mN_address            word address                      (in,  ADDR_W)
//   mN_byteenable         write byte lanes                  (in,  4)
//   mN_read, mN_write     request strobes; both high = write (in,  1)
//   mN_writedata          write data                        (in,  32)
//   mN_waitrequest        request not taken this cycle      (out, 1)
//   mN_readdata           shared read-return bus            (out, 32)
//   mN_readdatavalid      read-return strobe for master N   (out, 1)
//   mem_address .. mem_clken   drive of the memory s1 port  (out)
//   mem_readdata          memory output, valid one cycle after the address
// -----------------------------------------------------------------------------
module first_nios2_system_onchip_mem_arbiter #(
   parameter int DEPTH  = 9896,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [3:0]        m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [31:0]       m0_writedata,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [3:0]        m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata
);

   // One extra bit so the bound compares correctly even when DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   logic              req0;
   logic              req1;
   logic              gnt_valid;   // some master is granted this cycle
   logic              gnt_sel;     // 0 = m0, 1 = m1 (meaningful with gnt_valid)

   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_be;
   logic [31:0]       sel_wdata;
   logic              sel_write;
   logic              sel_read;
   logic              in_range;

   logic              rd_valid_q, rd_valid_d;
   logic              rd_owner_q, rd_owner_d;
   logic              rd_oor_q,   rd_oor_d;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifndef ONCHIP_ARB_FIXED_PRIORITY_EN
   // Master granted most recently; the other one wins the next contention.
   logic last_grant_q, last_grant_d;
`endif

   // ---------------------------------------------------------------------------
   // Grant decision. No grant at all while reset is held, so nothing reaches
   // the memory and every requester sees waitrequest.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the if/else leaves it unassigned (which would be a latch).
      gnt_valid = 1'b0;
      gnt_sel   = 1'b0;
      if (reset_n) begin
         if (req0 && req1) begin
            gnt_valid = 1'b1;
`ifdef ONCHIP_ARB_FIXED_PRIORITY_EN
            gnt_sel   = 1'b0;
`else
            gnt_sel   = ~last_grant_q;
`endif
         end else if (req0) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b0;
         end else if (req1) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Request mux toward the memory
   // ---------------------------------------------------------------------------
   assign sel_addr  = gnt_sel ? m1_address    : m0_address;
   assign sel_be    = gnt_sel ? m1_byteenable : m0_byteenable;
   assign sel_wdata = gnt_sel ? m1_writedata  : m0_writedata;
   assign sel_write = gnt_sel ? m1_write      : m0_write;
   // A simultaneous read+write is a write and never produces read data.
   assign sel_read  = (gnt_sel ? m1_read : m0_read) & ~sel_write;
   assign in_range  = {1'b0, sel_addr} < DEPTH_W;

   assign mem_address    = sel_addr;
   assign mem_byteenable = sel_be;
   assign mem_writedata  = sel_wdata;
   assign mem_chipselect = gnt_valid & in_range;
   assign mem_write      = gnt_valid & sel_write & in_range;
   assign mem_clken      = 1'b1;

   assign m0_waitrequest = req0 & ~(gnt_valid & ~gnt_sel);
   assign m1_waitrequest = req1 & ~(gnt_valid &  gnt_sel);

   // ---------------------------------------------------------------------------
   // Read-return pipeline: one stage matching the memory's address register.
   // ---------------------------------------------------------------------------
   assign rd_valid_d = gnt_valid & sel_read;
   assign rd_owner_d = gnt_sel;
   assign rd_oor_d   = ~in_range;

   // NOTE: state registers use non-blocking assignments and an asynchronous
   // active-low reset, so reset drops a pending read return immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_oor_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

`ifndef ONCHIP_ARB_FIXED_PRIORITY_EN
   assign last_grant_d = gnt_valid ? gnt_sel : last_grant_q;

   // Reset to m1 so that m0 wins the first contention.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Both masters share one data bus; only the valid strobe is steered.
   assign m0_readdata      = rd_oor_q ? 32'h0 : mem_readdata;
   assign m1_readdata      = rd_oor_q ? 32'h0 : mem_readdata;
   assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
   assign m1_readdatavalid = rd_valid_q &  rd_owner_q;

endmodule
